// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial adder computing {cout,sum} = op_a + op_b + cin.
// One operand bit is consumed per SHIFT cycle, LSB first; the result is
// published only when the last bit has been added.
// Optional feature macro: SERIAL_ADD_SEQ_OVF_EN adds a registered signed
// overflow output 'ovf'.
module serial_add_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             shift_ctrl,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_SEQ_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] psum_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic             bit_s;
    logic             carry_nxt;
    logic             last_bit;

    // Full-adder slice on the current LSBs and the running carry.
    assign bit_s     = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    assign last_bit  = (cnt_q == CW'(WIDTH - 1));

    // State register; reset wins over any pending start.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and Moore outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case statement can leave a signal unassigned and infer a latch.
        state_nxt  = state;
        busy       = 1'b0;
        shift_ctrl = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy       = 1'b1;
                shift_ctrl = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, serial add, and result publication on the final bit.
    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are few and an aborted add must leave
        // no trace, so all of them are cleared on reset (this is not a RAM).
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADD_SEQ_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    psum_q  <= {bit_s, psum_q[WIDTH-1:1]};
                    carry_q <= carry_nxt;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_bit) begin
                        sum  <= {bit_s, psum_q[WIDTH-1:1]};
                        cout <= carry_nxt;
`ifdef SERIAL_ADD_SEQ_OVF_EN
                        // carry_q is the carry into the MSB on this edge.
                        ovf  <= carry_q ^ carry_nxt;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: directed bench for serial_add_seq (WIDTH=4).
// Expected results are queued when a request is accepted and compared
// whenever the DUT pulses done. Define SERIAL_ADD_SEQ_OVF_EN to also check ovf.
module tb_serial_add_seq;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         shift_ctrl;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_SEQ_OVF_EN
    logic         ovf;
`endif

    exp_t         sb[$];
    int           vectors    = 0;
    int           miscompares = 0;
    int           n_push     = 0;
    int           n_done     = 0;
    logic [W-1:0] last_sum   = '0;
    logic         last_cout  = 1'b0;

    serial_add_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .cin        (cin),
        .busy       (busy),
        .shift_ctrl (shift_ctrl),
        .done       (done),
        .sum        (sum),
`ifdef SERIAL_ADD_SEQ_OVF_EN
        .ovf        (ovf),
`endif
        .cout       (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp_t         e;
        logic [W:0]   full;
        int           sa;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        sa     = int'($signed(a));
        sa     = sa + int'($signed(b));
        sa     = sa + int'(c);
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (sa > (2 ** (W - 1)) - 1) || (sa < -(2 ** (W - 1)));
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                check("done_without_request", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sum", 32'(sum), 32'(e.sum));
                check("cout", 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADD_SEQ_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // One complete add. pulse_k >= 0 re-asserts start (with new operands)
    // in that SHIFT cycle and again in the DONE cycle; both must be ignored.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input int pulse_k);
        exp_t e;
        e     = model(a, b, c);
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        sb.push_back(e);
        n_push++;
        tick();
        // Operands change after acceptance and must not matter.
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        cin   = 1'($urandom);
        for (int k = 0; k < W; k++) begin
            start = (k == pulse_k);
            check("shift_ctrl_in_shift", 32'(shift_ctrl), 32'd1);
            check("busy_in_shift", 32'(busy), 32'd1);
            check("sum_holds_in_shift", 32'(sum), 32'(last_sum));
            check("cout_holds_in_shift", 32'(cout), 32'(last_cout));
            tick();
        end
        start = (pulse_k >= 0);
        check("done_latency", 32'(done), 32'd1);
        check("shift_ctrl_in_done", 32'(shift_ctrl), 32'd0);
        check("busy_in_done", 32'(busy), 32'd1);
        tick();
        start = 1'b0;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
        last_sum  = e.sum;
        last_cout = e.cout;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_shift_ctrl", 32'(shift_ctrl), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;

        // Basic adds including carry-out, signed overflow and carry-in cases.
        do_op(4'b1010, 4'b0011, 1'b0, -1);
        do_op(4'b1111, 4'b0001, 1'b0, -1);
        do_op(4'b0111, 4'b0001, 1'b0, -1);
        do_op(4'b0111, 4'b1000, 1'b1, -1);

        // start pulsed during SHIFT and DONE is ignored.
        do_op(4'b0110, 4'b0101, 1'b1, 1);
        tick();
        check("no_queued_start", 32'(busy), 32'd0);

        // Reset in the second SHIFT cycle aborts without a done pulse.
        op_a  = 4'b1100;
        op_b  = 4'b0110;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        last_sum  = '0;
        last_cout = 1'b0;
        // First edge with rst low accepts immediately.
        rst = 1'b0;
        do_op(4'b0101, 4'b0101, 1'b0, -1);

        // start held high for 20 edges: accepts on edges 1,7,13,19.
        op_a  = 4'b0001;
        op_b  = 4'b0001;
        cin   = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(model(4'b0001, 4'b0001, 1'b0));
            n_push++;
        end
        for (int e = 1; e <= 26; e++) begin
            tick();
            if (e == 20) begin
                start = 1'b0;
            end
            check($sformatf("b2b_done_edge%0d", e), 32'(done), 32'((e % 6) == 5));
        end

        tick();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("done_pulse_count", 32'(n_done), 32'(n_push));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
